// File: rtl/seg_display_arbiter.sv
// Round-robin arbiter sharing the seven-segment display write port between
// the CPU bus bridge (src0) and the debug monitor (src1). Each grant gives the
// writer a hold window so the displayed value stays readable.
module seg_display_arbiter #(
  parameter int HOLD_CYCLES = 50000,
  parameter int CNT_W       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [31:0] data0,
  input  logic        req1,
  input  logic [31:0] data1,
  output logic        ack0,
  output logic        ack1,
  output logic        write_enable,
  output logic [31:0] data_to_led,
  output logic [1:0]  owner
);

  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  // State encoding doubles as the owner output code.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rr_q, rr_d;
  logic               ack0_q, ack0_d;
  logic               ack1_q, ack1_d;
  logic               we_q, we_d;
  logic [31:0]        data_q, data_d;

  logic               req0_v, req1_v;
  logic               grant0, grant1;

  // A request is masked in the cycle its own ack is visible, so a requester
  // that drops req on seeing ack is never granted twice.
  assign req0_v = req0 && !ack0_q;
  assign req1_v = req1 && !ack1_q;

  // Arbitration, hold-window countdown and grant side effects.
  always_comb begin
    grant0  = 1'b0;
    grant1  = 1'b0;
    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    we_d    = 1'b0;
    data_d  = data_q;

    case (state_q)
      IDLE: begin
        if (req0_v && (!req1_v || !rr_q)) grant0 = 1'b1;
        else if (req1_v)                   grant1 = 1'b1;
      end
      OWN0: begin
        if (req0_v) begin
          grant0 = 1'b1;
        end else if (cnt_q <= ONE) begin
          if (req1_v) begin
            grant1 = 1'b1;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      OWN1: begin
        if (req1_v) begin
          grant1 = 1'b1;
        end else if (cnt_q <= ONE) begin
          if (req0_v) begin
            grant0 = 1'b1;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (grant0) begin
      state_d = OWN0;
      cnt_d   = HOLD_LD;
      rr_d    = 1'b1;
      ack0_d  = 1'b1;
      we_d    = 1'b1;
      data_d  = data0;
    end else if (grant1) begin
      state_d = OWN1;
      cnt_d   = HOLD_LD;
      rr_d    = 1'b0;
      ack1_d  = 1'b1;
      we_d    = 1'b1;
      data_d  = data1;
    end
  end

  // Registered state and outputs; reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rr_q    <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      we_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      we_q    <= we_d;
      data_q  <= data_d;
    end
  end

  assign ack0         = ack0_q;
  assign ack1         = ack1_q;
  assign write_enable = we_q;
  assign data_to_led  = data_q;
  assign owner        = state_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Bench for seg_display_arbiter with a 4-cycle hold window. Expected grants
// (source, data, cycle) are queued by the stimulus; a monitor pops and checks
// one entry for every write strobe the DUT presents.
module tb_seg_display_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic [31:0] data0, data1;
  logic        ack0, ack1, write_enable;
  logic [31:0] data_to_led;
  logic [1:0]  owner;

  seg_display_arbiter #(.HOLD_CYCLES(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .data0(data0),
    .req1(req1), .data1(data1),
    .ack0(ack0), .ack1(ack1),
    .write_enable(write_enable),
    .data_to_led(data_to_led),
    .owner(owner)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          src;
    logic [31:0] data;
    int          at;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;
  int rearm0 = 0;
  int rearm1 = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic chk_zero(string tag);
    chk({tag, "_ack0"},  {31'b0, ack0}, 32'd0);
    chk({tag, "_ack1"},  {31'b0, ack1}, 32'd0);
    chk({tag, "_we"},    {31'b0, write_enable}, 32'd0);
    chk({tag, "_data"},  data_to_led, 32'd0);
    chk({tag, "_owner"}, {30'b0, owner}, 32'd0);
  endtask

  task automatic wait_to(int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Monitor: every strobe must match the oldest expected grant.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (write_enable || ack0 || ack1)) begin
        if (sb.size() == 0) begin
          chk("unexpected_write", {29'b0, write_enable, ack1, ack0}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("ack0",        {31'b0, ack0}, (e.src == 0) ? 32'd1 : 32'd0);
          chk("ack1",        {31'b0, ack1}, (e.src == 1) ? 32'd1 : 32'd0);
          chk("write_en",    {31'b0, write_enable}, 32'd1);
          chk("data_to_led", data_to_led, e.data);
          chk("owner",       {30'b0, owner}, (e.src == 0) ? 32'd1 : 32'd2);
          chk("grant_cycle", cyc, e.at);
        end
      end
    end
  end

  // Requester 0: drop req on ack; optionally re-request after src1 is granted.
  initial begin
    forever begin
      @(negedge clk);
      if (ack0) begin
        req0 = 1'b0;
      end else if (ack1 && rearm0 > 0 && !req0) begin
        rearm0--;
        data0 = data0 + 32'd1;
        req0  = 1'b1;
      end
    end
  end

  // Requester 1: same behaviour, mirrored.
  initial begin
    forever begin
      @(negedge clk);
      if (ack1) begin
        req1 = 1'b0;
      end else if (ack0 && rearm1 > 0 && !req1) begin
        rearm1--;
        data1 = data1 + 32'd1;
        req1  = 1'b1;
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  // Directed stimulus.
  initial begin
    int c;
    int k;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset_state");
    rst = 1'b0;
    @(negedge clk);

    // Single request from idle, then release after the hold window.
    c = cyc;
    data0 = 32'h12345678; req0 = 1'b1;
    sb.push_back('{0, 32'h12345678, c + 1});
    wait_to(c + 4);
    chk("t2_owner_held", {30'b0, owner}, 32'd1);
    wait_to(c + 5);
    chk("t2_owner_idle", {30'b0, owner}, 32'd0);
    wait_to(c + 8);
    chk("t2_pending", sb.size(), 32'd0);

    // Both request after reset: src0 first, src1 exactly 4 cycles later.
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    c = cyc;
    data0 = 32'h11111111; data1 = 32'hDEADBEEF; req0 = 1'b1; req1 = 1'b1;
    sb.push_back('{0, 32'h11111111, c + 1});
    sb.push_back('{1, 32'hDEADBEEF, c + 5});
    wait_to(c + 10);
    chk("t3_owner_idle", {30'b0, owner}, 32'd0);
    chk("t3_pending", sb.size(), 32'd0);

    // src0 regrants 2 cycles into its window; src1 waits 4 cycles past it.
    c = cyc;
    data0 = 32'h00000044; data1 = 32'h00000055; req0 = 1'b1; req1 = 1'b1;
    sb.push_back('{0, 32'h00000044, c + 1});
    wait_to(c + 2);
    data0 = 32'h00000066; req0 = 1'b1;
    sb.push_back('{0, 32'h00000066, c + 3});
    sb.push_back('{1, 32'h00000055, c + 7});
    wait_to(c + 12);
    chk("t4_pending", sb.size(), 32'd0);

    // Both keep requesting: strict alternation with no idle gap.
    c = cyc;
    data0 = 32'hA0000000; data1 = 32'hB0000000;
    rearm0 = 2; rearm1 = 2;
    req0 = 1'b1; req1 = 1'b1;
    sb.push_back('{0, 32'hA0000000, c + 1});
    sb.push_back('{1, 32'hB0000000, c + 5});
    sb.push_back('{0, 32'hA0000001, c + 9});
    sb.push_back('{1, 32'hB0000001, c + 13});
    sb.push_back('{0, 32'hA0000002, c + 17});
    sb.push_back('{1, 32'hB0000002, c + 21});
    for (int t = c + 1; t <= c + 24; t += 3) begin
      wait_to(t);
      chk("t5_no_idle", {31'b0, owner != 2'b00}, 32'd1);
    end
    wait_to(c + 27);
    chk("t5_pending", sb.size(), 32'd0);
    chk("t5_owner_idle", {30'b0, owner}, 32'd0);

    // Reset mid-hold with src1 waiting: outputs clear at once, then src1 wins.
    c = cyc;
    data0 = 32'h00000077; data1 = 32'h00000088; req0 = 1'b1; req1 = 1'b1;
    sb.push_back('{0, 32'h00000077, c + 1});
    wait_to(c + 3);
    rst = 1'b1;
    sb.delete();
    #1;
    chk_zero("async_reset");
    @(negedge clk);
    chk_zero("reset_held");
    k = cyc;
    rst = 1'b0;
    sb.push_back('{1, 32'h00000088, k + 1});
    wait_to(k + 2);
    chk("t6_owner", {30'b0, owner}, 32'd2);
    wait_to(k + 7);
    chk("t6_pending", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
